bitwise_pipe: RTL and testbench
===============================

BITWISE_PIPE -- requirements
Module: bitwise_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width in bits (legal range 1..64).
REQ-002 SHALL have parameter STAGES, default 2, number of register stages (legal range 1..8).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  input operand set present.
REQ-006 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-007 SHALL have port a  input  WIDTH  first operand.
REQ-008 SHALL have port b  input  WIDTH  second operand (ignored by unary ops).
REQ-009 SHALL have port op  input  3  operation select.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port out  output  WIDTH  result.
REQ-013 SHALL have port busy  output  1  high while any stage holds valid data.
REQ-014 SHALL have port txn_count  output  16  completed output handshakes.

Function
REQ-015 SHALL encode op: 0 NOT a, 1 AND, 2 OR, 3 XOR, 4 NAND, 5 NOR, 6 XNOR, 7 PASS a; all ops bitwise over WIDTH.
REQ-016 SHALL accept input on in_valid && in_ready; compute result combinationally and capture it into stage 1 in that same cycle.
REQ-017 SHALL move data stage k -> k+1 when stage k+1 is empty or advancing; last stage drives out/out_valid directly from registers.
REQ-018 SHALL give latency of exactly STAGES cycles from input handshake to out_valid when out_ready is held high.
REQ-019 SHALL sustain one transaction per cycle with out_ready high; no bubbles inserted.
REQ-020 SHALL assert in_ready = !stage1_valid || stage1 advancing; combinational ready path through all stages is permitted.
REQ-021 SHALL hold out stable and out_valid high while out_valid && !out_ready; no data lost or duplicated under any backpressure pattern.
REQ-022 SHALL preserve transaction order; each result returns its own op/operands regardless of op changes on consecutive inputs.
REQ-023 SHALL, with all stages full and out_ready low, deassert in_ready; simultaneous output drain and input accept in one cycle SHALL be allowed.
REQ-024 SHALL increment txn_count on each out_valid && out_ready; wrap 16'hFFFF -> 16'h0000.
REQ-025 SHALL drive busy = OR of all stage valid bits.
REQ-026 SHALL leave out at its last value when out_valid is low (no zeroing on drain).

Reset
REQ-027 SHALL, on rst_n low, immediately clear all stage valid bits, out, and txn_count to 0, independent of clk.
REQ-028 SHALL, during and right after reset: out_valid=0, busy=0, in_ready=1, out=0, txn_count=0.
REQ-029 SHALL discard in-flight data on reset mid-operation; first post-reset result appears STAGES cycles after first post-reset handshake.

Structure
REQ-030 SHALL place op code constants (OP_NOT..OP_PASS) and op width in shared package bitwise_pkg.
REQ-031 SHALL implement one register stage as sub-module bitwise_stage (valid bit, WIDTH data, ready in/out), instantiated STAGES times via generate.
REQ-032 SHALL keep the op decode as a single combinational function in bitwise_pkg, reused by the bench's reference model.

Verification
REQ-033 Bench SHALL sweep all 8 ops with WIDTH=16, a=16'hA5F0, b=16'h0FF0, out_ready=1 -> e.g. NOT=16'h5A0F, AND=16'h05F0, XOR=16'hAA00, each exactly 2 cycles after handshake.
REQ-034 Bench SHALL stream 1000 random inputs with random out_ready (50%) -> results match model in order, txn_count=1000, no stall with out_ready=1 stretches.
REQ-035 Bench SHALL fill pipe with out_ready=0 -> in_ready low after STAGES accepts, out held constant; release -> STAGES results drain back-to-back.
REQ-036 Bench SHALL assert rst_n low mid-stream with 2 items in flight -> out_valid=0, busy=0, txn_count=0 asynchronously; no stale result after release.
REQ-037 Bench SHALL preload 65535 handshakes then one more -> txn_count wraps to 0.
REQ-038 Bench SHALL repeat REQ-033 with WIDTH=1 STAGES=1 and WIDTH=64 STAGES=8 -> latency equals STAGES, exhaustive 1-bit truth tables correct.

Source files
------------

// File: rtl/bitwise_pkg.sv
// bitwise_pkg: shared op encoding and the combinational op decode used by
// bitwise_pipe and its reference model.
//   OP_W      : width of the op select
//   OP_*      : op codes
//   MAX_W     : widest supported data path
//   bw_op()   : bitwise result for a given op, operands zero-extended to MAX_W
package bitwise_pkg;

   localparam int OP_W  = 3;
   localparam int MAX_W = 64;

   localparam logic [OP_W-1:0] OP_NOT  = 3'd0;
   localparam logic [OP_W-1:0] OP_AND  = 3'd1;
   localparam logic [OP_W-1:0] OP_OR   = 3'd2;
   localparam logic [OP_W-1:0] OP_XOR  = 3'd3;
   localparam logic [OP_W-1:0] OP_NAND = 3'd4;
   localparam logic [OP_W-1:0] OP_NOR  = 3'd5;
   localparam logic [OP_W-1:0] OP_XNOR = 3'd6;
   localparam logic [OP_W-1:0] OP_PASS = 3'd7;

   // Callers truncate the result back to their own width; upper bits of
   // inverting ops are junk for narrow operands and must be discarded.
   function automatic logic [MAX_W-1:0] bw_op(input logic [OP_W-1:0]  op,
                                              input logic [MAX_W-1:0] a,
                                              input logic [MAX_W-1:0] b);
      logic [MAX_W-1:0] r;
      case (op)
         OP_NOT:  r = ~a;
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_NAND: r = ~(a & b);
         OP_NOR:  r = ~(a | b);
         OP_XNOR: r = ~(a ^ b);
         default: r = a;          // OP_PASS
      endcase
      return r;
   endfunction

endpackage

// File: rtl/bitwise_pipe_stage.sv
// bitwise_stage: one elastic register slot (valid + data) of the pipe.
//   clk, rst_n       : clock, async active-low reset
//   i_valid, i_data  : upstream offer
//   o_ready          : this slot can take the upstream offer this cycle
//   o_valid, o_data  : registered slot contents
//   i_ready          : downstream takes o_data this cycle
module bitwise_stage
   import bitwise_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_ready,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   input  logic             i_ready
);

   logic             r_valid;
   logic [WIDTH-1:0] r_data;

   // Ready when empty or when the current occupant leaves this cycle.
   assign o_ready = !r_valid || i_ready;
   assign o_valid = r_valid;
   assign o_data  = r_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (o_ready) begin
         r_valid <= i_valid;
         // Data only loads with a real item so the output holds its last
         // value once the pipe drains.
         if (i_valid) r_data <= i_data;
      end
   end

endmodule

// File: rtl/bitwise_pipe.sv
// bitwise_pipe: bitwise ALU followed by a STAGES-deep elastic register pipe.
//   clk, rst_n              : clock, async active-low reset
//   in_valid/in_ready       : input handshake for a, b, op
//   out_valid/out_ready/out : output handshake, out driven from last stage
//   busy                    : any stage holds an item
//   txn_count               : wrapping count of output handshakes
module bitwise_pipe
   import bitwise_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OP_W-1:0]  op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             busy,
   output logic [15:0]      txn_count
);

   // Index 0 is the combinational ALU result, index k the output of stage k.
   logic [STAGES:0]            w_valid;
   logic [STAGES:0][WIDTH-1:0] w_data;
   logic [15:0]                r_txn_count;

   assign w_valid[0] = in_valid;
   assign w_data[0]  = WIDTH'(bw_op(op, MAX_W'(a), MAX_W'(b)));

   // The ready chain lives in per-stage signals so each link is its own net
   // rather than bits of one vector feeding each other.
   for (genvar k = 1; k <= STAGES; k++) begin : g_stage
      logic w_up_ready;
      logic w_dn_ready;

      if (k == STAGES) begin : g_last
         assign w_dn_ready = out_ready;
      end else begin : g_mid
         assign w_dn_ready = g_stage[k+1].w_up_ready;
      end

      bitwise_stage #(.WIDTH(WIDTH)) u_stage (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_valid (w_valid[k-1]),
         .i_data  (w_data[k-1]),
         .o_ready (w_up_ready),
         .o_valid (w_valid[k]),
         .o_data  (w_data[k]),
         .i_ready (w_dn_ready)
      );
   end

   assign in_ready  = g_stage[1].w_up_ready;
   assign out_valid = w_valid[STAGES];
   assign out       = w_data[STAGES];
   assign busy      = |w_valid[STAGES:1];
   assign txn_count = r_txn_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      r_txn_count <= '0;
      else if (out_valid && out_ready) r_txn_count <= r_txn_count + 16'd1;
   end

endmodule

// File: tb/tb_bitwise_pipe.sv
// tb_bitwise_pipe: directed bench for bitwise_pipe at three shapes
// (16b/2 stages, 1b/1 stage, 64b/8 stages).
module tb_bitwise_pipe;
   import bitwise_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // 16-bit, 2-stage
   logic        iv, ir, ov, ordy, busy;
   logic [15:0] a16, b16, out16, txn;
   logic [2:0]  op;
   // 1-bit, 1-stage
   logic        iv1, ir1, ov1, ordy1, busy1, a1, b1, out1;
   logic [15:0] txn1;
   logic [2:0]  op1;
   // 64-bit, 8-stage
   logic        iv8, ir8, ov8, ordy8, busy8;
   logic [63:0] a64, b64, out64;
   logic [15:0] txn8;
   logic [2:0]  op8;

   bitwise_pipe #(.WIDTH(16), .STAGES(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .a(a16), .b(b16),
      .op(op), .out_valid(ov), .out_ready(ordy), .out(out16), .busy(busy),
      .txn_count(txn));

   bitwise_pipe #(.WIDTH(1), .STAGES(1)) u_d1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
      .op(op1), .out_valid(ov1), .out_ready(ordy1), .out(out1), .busy(busy1),
      .txn_count(txn1));

   bitwise_pipe #(.WIDTH(64), .STAGES(8)) u_d8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a64), .b(b64),
      .op(op8), .out_valid(ov8), .out_ready(ordy8), .out(out64), .busy(busy8),
      .txn_count(txn8));

   int checks = 0;
   int errors = 0;
   logic [15:0] q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0][15:0] exp16;
      logic [7:0][3:0]  tt1;
      logic [63:0]      r;
      logic [15:0]      held;
      logic             prev_stall;
      int               lat, n, sent, cyc;

      // Hand-computed for a=A5F0 b=0FF0, index = op.
      exp16 = {16'hA5F0, 16'h55FF, 16'h500F, 16'hFA0F,
               16'hAA00, 16'hAFF0, 16'h05F0, 16'h5A0F};
      // 1-bit truth tables, bit index = {a,b}.
      tt1 = {4'b1100, 4'b1001, 4'b0001, 4'b0111,
             4'b0110, 4'b1110, 4'b1000, 4'b0011};

      iv = 0; ordy = 0; a16 = 0; b16 = 0; op = 0;
      iv1 = 0; ordy1 = 0; a1 = 0; b1 = 0; op1 = 0;
      iv8 = 0; ordy8 = 0; a64 = 0; b64 = 0; op8 = 0;

      // ---- reset state
      #2;
      check("rst_ov", ov, 0);
      check("rst_busy", busy, 0);
      check("rst_ir", ir, 1);
      check("rst_out", out16, 0);
      check("rst_txn", txn, 0);
      #10 rst_n = 1'b1;
      step();
      check("post_rst_ir", ir, 1);
      check("post_rst_ov", ov, 0);

      // ---- op sweep, 16b/2 stages
      for (int i = 0; i < 8; i++) begin
         iv = 1; a16 = 16'hA5F0; b16 = 16'h0FF0; op = 3'(i); ordy = 1;
         step();
         iv = 0; lat = 1;
         while (!ov && lat < 20) begin step(); lat++; end
         check("lat16", lat, 2);
         check("op16", out16, exp16[i]);
      end
      step();

      // ---- op sweep, 64b/8 stages
      for (int i = 0; i < 8; i++) begin
         iv8 = 1; a64 = {4{16'hA5F0}}; b64 = {4{16'h0FF0}}; op8 = 3'(i); ordy8 = 1;
         step();
         iv8 = 0; lat = 1;
         while (!ov8 && lat < 40) begin step(); lat++; end
         check("lat64", lat, 8);
         check("op64", out64, {4{exp16[i]}});
      end

      // ---- exhaustive truth tables, 1b/1 stage
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 4; j++) begin
            iv1 = 1; a1 = 1'(j >> 1); b1 = 1'(j); op1 = 3'(i); ordy1 = 1;
            step();
            iv1 = 0; lat = 1;
            while (!ov1 && lat < 20) begin step(); lat++; end
            check("lat1", lat, 1);
            check("tt1", out1, tt1[i][j]);
         end
      end

      // ---- fill with backpressure, then drain
      ordy = 0; iv = 1; op = OP_PASS; b16 = 0; n = 0;
      while (n < 10) begin
         a16 = 16'h1111 * 16'(n + 1);
         #1;
         if (!ir) break;
         n++;
         step();
      end
      iv = 0;
      check("fill_accepts", n, 2);
      check("fill_busy", busy, 1);
      for (int i = 0; i < 3; i++) begin
         check("stall_ov", ov, 1);
         check("stall_out", out16, 16'h1111);
         check("stall_ir", ir, 0);
         step();
      end
      ordy = 1;
      #1;
      check("drain_ir", ir, 1);
      check("drain0_ov", ov, 1);
      check("drain0_out", out16, 16'h1111);
      step();
      check("drain1_ov", ov, 1);
      check("drain1_out", out16, 16'h2222);
      step();
      check("drained_ov", ov, 0);
      check("drained_hold", out16, 16'h2222);
      check("drained_busy", busy, 0);
      check("txn_10", txn, 10);

      // ---- async reset with two items in flight
      iv = 1; op = OP_XOR; a16 = 16'h1234; b16 = 16'h00FF;
      step();
      a16 = 16'h4321;
      step();
      iv = 0;
      check("pre_rst_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_ov", ov, 0);
      check("arst_busy", busy, 0);
      check("arst_txn", txn, 0);
      check("arst_out", out16, 0);
      check("arst_ir", ir, 1);
      step();
      step();
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (ov) n++;
      end
      check("no_stale", n, 0);
      iv = 1; op = OP_AND; a16 = 16'hFF00; b16 = 16'h0FF0;
      step();
      iv = 0; lat = 1;
      while (!ov && lat < 20) begin step(); lat++; end
      check("post_rst_lat", lat, 2);
      check("post_rst_res", out16, 16'h0F00);
      step();

      // ---- random stream with random backpressure
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      sent = 0; prev_stall = 0; held = 0; q.delete();
      for (cyc = 0; cyc < 20000 && (sent < 1000 || q.size() > 0); cyc++) begin
         iv   = (sent < 1000) && ($urandom_range(0, 3) != 0);
         a16  = 16'($urandom);
         b16  = 16'($urandom);
         op   = 3'($urandom_range(0, 7));
         ordy = ($urandom_range(0, 1) == 1);
         #1;
         if (prev_stall) begin
            check("hold_ov", ov, 1);
            check("hold_out", out16, held);
         end
         if (ordy) check("no_stall", ir, 1);
         if (ov && ordy) begin
            check("stream_nonempty", q.size() > 0, 1);
            if (q.size() > 0) check("stream", out16, q.pop_front());
         end
         if (iv && ir) begin
            r = bw_op(op, 64'(a16), 64'(b16));
            q.push_back(r[15:0]);
            sent++;
         end
         prev_stall = ov && !ordy;
         held = out16;
         step();
      end
      iv = 0;
      check("stream_sent", sent, 1000);
      check("stream_left", q.size(), 0);
      check("stream_txn", txn, 1000);

      // ---- txn_count wrap
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      iv = 1; ordy = 1; op = OP_PASS; a16 = 16'hBEEF;
      cyc = 0;
      while (txn != 16'hFFFF && cyc < 70000) begin step(); cyc++; end
      check("txn_ffff", txn, 16'hFFFF);
      iv = 0;
      check("wrap_ov", ov, 1);
      step();
      check("txn_wrap", txn, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
